// File: rtl/adc_max10_trigger_timer.sv
// adc_max10_trigger_timer: prescaled periodic/one-shot trigger for the MAX10 ADC controller
module adc_max10_trigger_timer #(
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 16,
  parameter int OVR_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_data,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [31:0]           write_data,
  input  logic                  write_enable,
  input  logic                  ADC_Busy,
  output logic                  ADC_Trigger,
  output logic                  TMR_Interrupt
);
  logic en, os, ie, iflag, trig;
  logic [CNT_WIDTH-1:0] psc, per, cnt, pcnt;
  logic [OVR_WIDTH-1:0] ovr;
  logic cs_wr, ovr_clr, start, tick, fire, inc;
  logic unused_bits;
  assign cs_wr   = write_enable && write_addr == ADDR_WIDTH'(0);
  assign ovr_clr = write_enable && write_addr == ADDR_WIDTH'(4);
  assign start   = cs_wr && write_data[0] && !en;
  assign tick    = en && pcnt == psc;
  // >= so a period lowered below the running count fires at once rather than wrapping
  assign fire    = tick && cnt >= per;
  assign inc     = fire && ADC_Busy;
  assign unused_bits = ^write_data[31:CNT_WIDTH];
  always_ff @(posedge CLK) begin
    if (RESET) begin
      en    <= 1'b0;
      os    <= 1'b0;
      ie    <= 1'b0;
      iflag <= 1'b0;
      trig  <= 1'b0;
      psc   <= '0;
      per   <= '0;
      cnt   <= '0;
      pcnt  <= '0;
      ovr   <= '0;
    end else begin
      if (cs_wr) begin
        en <= write_data[0];
        os <= write_data[1];
        ie <= write_data[2];
      end else if (fire && os) begin
        en <= 1'b0;
      end
      iflag <= (fire && ie) || (iflag && !(cs_wr && write_data[3]));
      if (write_enable && write_addr == ADDR_WIDTH'(1)) psc <= write_data[CNT_WIDTH-1:0];
      if (write_enable && write_addr == ADDR_WIDTH'(2)) per <= write_data[CNT_WIDTH-1:0];
      pcnt <= (start || tick) ? '0 : en ? pcnt + CNT_WIDTH'(1) : pcnt;
      cnt  <= (start || fire) ? '0 : tick ? cnt + CNT_WIDTH'(1) : cnt;
      ovr  <= ovr_clr ? OVR_WIDTH'(inc) : (inc && !(&ovr)) ? ovr + OVR_WIDTH'(1) : ovr;
      trig <= fire;
    end
  end
  always_comb begin
    read_data = read_addr == ADDR_WIDTH'(0) ? {28'b0, iflag, ie, os, en} :
                read_addr == ADDR_WIDTH'(1) ? 32'(psc) :
                read_addr == ADDR_WIDTH'(2) ? 32'(per) :
                read_addr == ADDR_WIDTH'(3) ? 32'(cnt) :
                read_addr == ADDR_WIDTH'(4) ? 32'(ovr) : 32'b0;
  end
  assign ADC_Trigger   = trig;
  assign TMR_Interrupt = iflag;
endmodule
